// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg: shared types and constants for the SRAM controller.
//   state_t      - controller FSM states (3-bit encoding)
//   SRAM_DATA_W  - external SRAM data width (16)
//   SRAM_ADDR_W  - external SRAM half-word address width (18)
//   IDX_W        - word index width (one bit less than the SRAM address)
package sram_controller_pkg;

  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_ADDR_W = 18;
  localparam int IDX_W       = SRAM_ADDR_W - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_LO = 3'd1,
    WR_HI = 3'd2,
    RD_LO = 3'd3,
    RD_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/sram_controller_if.sv
// sram_controller_if: data-memory request bus between the MEM stage and the
// SRAM controller.
//   mem_r_en / mem_w_en - read / write request, held stable while ready = 0
//   address             - byte address
//   write_data          - store data
//   read_data           - load result (registered in the controller)
//   ready               - 0 = controller busy, pipeline must freeze
//
// Handshake: a request is taken when it is high in IDLE; ready drops in the
// same cycle and rises again for exactly one cycle (DONE). The requester
// keeps the request stable until the clock edge that ends the ready = 1
// cycle, and may present the next request immediately after it.
interface sram_controller_if;

  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output mem_r_en,
    output mem_w_en,
    output address,
    output write_data,
    input  read_data,
    input  ready
  );

  modport slave (
    input  mem_r_en,
    input  mem_w_en,
    input  address,
    input  write_data,
    output read_data,
    output ready
  );

endinterface

// File: rtl/sram_controller.sv
// sram_controller: maps 32-bit data-memory word accesses onto a 16-bit
// external SRAM as two half-word accesses, low half first.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   bus          - request bus (slave side of sram_controller_if)
//   sram_addr    - half-word address, {word index, half select}
//   sram_dq_out  - half-word driven during writes
//   sram_dq_in   - half-word returned by the SRAM during reads
//   sram_dq_oe   - 1 = drive sram_dq_out onto the bus
//   sram_we_n    - active-low write strobe
//   dbg_state    - current FSM state, for observation only
// Parameters:
//   BASE_ADDR     - byte address of data word 0
//   ACCESS_CYCLES - cycles spent in each half-word state (>= 1)
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int BASE_ADDR     = 1024,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_controller_if.slave       bus,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output state_t                 dbg_state
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      read_data_q, read_data_d;

  logic             last_cycle;
  logic [IDX_W-1:0] idx;

  // Out-of-range addresses simply wrap into the 17-bit index.
  assign idx        = IDX_W'((bus.address - 32'(BASE_ADDR)) >> 2);
  assign last_cycle = (cnt_q == '0);

  // Next-state, counter and read-capture logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    case (state_q)
      IDLE: begin
        // Write wins when both requests are present.
        if (bus.mem_w_en) begin
          state_d = WR_LO;
          cnt_d   = CNT_LOAD;
        end else if (bus.mem_r_en) begin
          state_d = RD_LO;
          cnt_d   = CNT_LOAD;
        end
      end
      WR_LO: begin
        if (last_cycle) begin
          state_d = WR_HI;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_HI: begin
        if (last_cycle) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_LO: begin
        if (last_cycle) begin
          read_data_d[15:0] = sram_dq_in;
          state_d           = RD_HI;
          cnt_d             = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_HI: begin
        if (last_cycle) begin
          read_data_d[31:16] = sram_dq_in;
          state_d            = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
    end
  end

  // SRAM pin drive. Reset forces the strobe and bus driver off immediately so
  // an access interrupted by reset never writes on the reset edge.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state_q)
      WR_LO: begin
        sram_addr   = {idx, 1'b0};
        sram_dq_out = bus.write_data[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
      WR_HI: begin
        sram_addr   = {idx, 1'b1};
        sram_dq_out = bus.write_data[31:16];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
      RD_LO: sram_addr = {idx, 1'b0};
      RD_HI: sram_addr = {idx, 1'b1};
      default: begin
        sram_addr = '0;
      end
    endcase
    if (rst) begin
      sram_dq_oe = 1'b0;
      sram_we_n  = 1'b1;
    end
  end

  // ready is combinational so it falls in the very cycle a request shows up.
  assign bus.ready = ((state_q == IDLE) && !bus.mem_r_en && !bus.mem_w_en) ||
                     (state_q == DONE);
  assign bus.read_data = read_data_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;
  import sram_controller_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // ---------------- DUT with ACCESS_CYCLES = 1 ----------------
  sram_controller_if if1();
  logic [17:0] sram_addr1;
  logic [15:0] sram_dq_out1, sram_dq_in1;
  logic        sram_dq_oe1, sram_we_n1;
  state_t      dbg1;
  logic [15:0] sram1 [0:262143];

  sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave),
    .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_in(sram_dq_in1),
    .sram_dq_oe(sram_dq_oe1), .sram_we_n(sram_we_n1), .dbg_state(dbg1)
  );

  always @(posedge clk) if (sram_we_n1 === 1'b0) sram1[sram_addr1] <= sram_dq_out1;
  assign sram_dq_in1 = sram1[sram_addr1];

  // ---------------- DUT with ACCESS_CYCLES = 3 ----------------
  sram_controller_if if3();
  logic [17:0] sram_addr3;
  logic [15:0] sram_dq_out3, sram_dq_in3;
  logic        sram_dq_oe3, sram_we_n3;
  state_t      dbg3;
  logic [15:0] sram3 [0:262143];

  sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave),
    .sram_addr(sram_addr3), .sram_dq_out(sram_dq_out3), .sram_dq_in(sram_dq_in3),
    .sram_dq_oe(sram_dq_oe3), .sram_we_n(sram_we_n3), .dbg_state(dbg3)
  );

  always @(posedge clk) if (sram_we_n3 === 1'b0) sram3[sram_addr3] <= sram_dq_out3;
  assign sram_dq_in3 = sram3[sram_addr3];

  // ---------------- driver ----------------
  // Issues one request on dut1, counts ready-low cycles until DONE, captures
  // read_data in DONE, then withdraws the request after the DONE edge.
  task automatic drive1(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, output int low_cnt,
                        output logic [31:0] rd, output logic timeout);
    @(posedge clk); #1;
    if1.mem_w_en = w; if1.mem_r_en = r; if1.address = a; if1.write_data = d;
    low_cnt = 0; timeout = 1'b1; rd = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (if1.ready === 1'b1 && dbg1 == DONE) begin
        rd = if1.read_data; timeout = 1'b0;
        break;
      end
      if (if1.ready !== 1'b1) low_cnt++;
    end
    @(posedge clk); #1;
    if1.mem_w_en = 1'b0; if1.mem_r_en = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (if1.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", if1.ready); end
    checks++; if (if1.read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data got=%h exp=0", if1.read_data); end
    checks++; if (sram_we_n1 !== 1'b1) begin errors++; $display("FAIL reset_we_n got=%b exp=1", sram_we_n1); end
    checks++; if (sram_dq_oe1 !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", sram_dq_oe1); end
    checks++; if (dbg1 !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg1, IDLE); end
    checks++; if (if3.read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data3 got=%h exp=0", if3.read_data); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write();
    int low; logic [31:0] rd; logic to;
    drive1(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, low, rd, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL write_timeout no DONE within budget"); end
    checks++; if (low != 3) begin errors++; $display("FAIL write_ready_low got=%0d exp=3", low); end
    checks++; if (sram1[0] !== 16'hBEEF) begin errors++; $display("FAIL write_lo got=%h exp=beef", sram1[0]); end
    checks++; if (sram1[1] !== 16'hDEAD) begin errors++; $display("FAIL write_hi got=%h exp=dead", sram1[1]); end
    @(negedge clk);
    checks++; if (if1.ready !== 1'b1 || dbg1 !== IDLE) begin errors++; $display("FAIL write_return_idle ready=%b state=%0d exp ready=1 state=0", if1.ready, dbg1); end
  endtask

  task automatic test_read_back();
    int low; logic [31:0] rd; logic to; logic [31:0] exp;
    exp_q.push_back(32'hDEADBEEF);
    drive1(1'b0, 1'b1, 32'd1024, 32'h0, low, rd, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL read_timeout no DONE within budget"); end
    checks++; if (low != 3) begin errors++; $display("FAIL read_ready_low got=%0d exp=3", low); end
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL read_data got=%h exp=%h", rd, exp); end
  endtask

  task automatic test_indexing();
    int low; logic [31:0] rd; logic to;
    drive1(1'b1, 1'b0, 32'd1032, 32'h12345678, low, rd, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL index_timeout no DONE within budget"); end
    checks++; if (sram1[4] !== 16'h5678) begin errors++; $display("FAIL index_lo got=%h exp=5678", sram1[4]); end
    checks++; if (sram1[5] !== 16'h1234) begin errors++; $display("FAIL index_hi got=%h exp=1234", sram1[5]); end
    checks++; if (sram1[0] !== 16'hBEEF || sram1[1] !== 16'hDEAD || sram1[2] !== 16'h0 || sram1[3] !== 16'h0) begin
      errors++; $display("FAIL index_others got=%h %h %h %h exp=beef dead 0000 0000", sram1[0], sram1[1], sram1[2], sram1[3]);
    end
    checks++; if (if1.read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL read_persist got=%h exp=deadbeef", if1.read_data); end
  endtask

  task automatic test_conflict();
    int low; logic [31:0] rd; logic to;
    drive1(1'b1, 1'b1, 32'd1028, 32'hA5A5_0F0F, low, rd, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL conflict_timeout no DONE within budget"); end
    checks++; if (sram1[2] !== 16'h0F0F) begin errors++; $display("FAIL conflict_lo got=%h exp=0f0f", sram1[2]); end
    checks++; if (sram1[3] !== 16'hA5A5) begin errors++; $display("FAIL conflict_hi got=%h exp=a5a5", sram1[3]); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL conflict_read_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_reset_mid_op();
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    if1.mem_w_en = 1'b1; if1.address = 32'd1036; if1.write_data = 32'hCAFEF00D;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (dbg1 == WR_HI) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL midrst_reach_wr_hi state=%0d", dbg1); end
    rst = 1'b1;
    #1;
    checks++; if (sram_we_n1 !== 1'b1 || sram_dq_oe1 !== 1'b0) begin errors++; $display("FAIL midrst_pins we_n=%b oe=%b exp 1 0", sram_we_n1, sram_dq_oe1); end
    @(posedge clk); #1;
    rst = 1'b0; if1.mem_w_en = 1'b0;
    @(negedge clk);
    checks++; if (dbg1 !== IDLE) begin errors++; $display("FAIL midrst_state got=%0d exp=0", dbg1); end
    checks++; if (sram_we_n1 !== 1'b1) begin errors++; $display("FAIL midrst_we_n got=%b exp=1", sram_we_n1); end
    checks++; if (sram1[6] !== 16'hF00D) begin errors++; $display("FAIL midrst_lo got=%h exp=f00d", sram1[6]); end
    checks++; if (sram1[7] !== 16'h0) begin errors++; $display("FAIL midrst_hi_written got=%h exp=0000", sram1[7]); end
    checks++; if (if1.read_data !== 32'h0) begin errors++; $display("FAIL midrst_read_data got=%h exp=0", if1.read_data); end
  endtask

  task automatic test_back_to_back();
    logic exp_ready; logic [31:0] exp;
    sram3[0] = 16'h1111; sram3[1] = 16'h2222;
    sram3[2] = 16'h3333; sram3[3] = 16'h4444;
    @(posedge clk); #1;
    if3.mem_r_en = 1'b1; if3.address = 32'd1024;
    exp_q.push_back(32'h2222_1111);
    exp_q.push_back(32'h4444_3333);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      // Each read: 7 busy cycles (IDLE + 3 LO + 3 HI) then one DONE cycle.
      exp_ready = ((c % 8) == 7);
      checks++; if (if3.ready !== exp_ready) begin errors++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, if3.ready, exp_ready); end
      if (c == 8) begin
        checks++; if (dbg3 !== IDLE) begin errors++; $display("FAIL b2b_gap_state got=%0d exp=0", dbg3); end
      end
      if (c == 7 || c == 15) begin
        exp = exp_q.pop_front();
        checks++; if (if3.read_data !== exp) begin errors++; $display("FAIL b2b_read_data c=%0d got=%h exp=%h", c, if3.read_data, exp); end
      end
      if (c == 7) begin
        @(posedge clk); #1;
        if3.address = 32'd1028;
      end
    end
    @(posedge clk); #1;
    if3.mem_r_en = 1'b0;
    @(negedge clk);
    checks++; if (if3.ready !== 1'b1 || dbg3 !== IDLE) begin errors++; $display("FAIL b2b_end ready=%b state=%0d exp 1 0", if3.ready, dbg3); end
  endtask

  // ---------------- main ----------------
  initial begin
    if1.mem_r_en = 1'b0; if1.mem_w_en = 1'b0; if1.address = '0; if1.write_data = '0;
    if3.mem_r_en = 1'b0; if3.mem_w_en = 1'b0; if3.address = '0; if3.write_data = '0;
    for (int i = 0; i < 262144; i++) begin
      sram1[i] = 16'h0;
      sram3[i] = 16'h0;
    end
    test_reset();
    test_write();
    test_read_back();
    test_indexing();
    test_conflict();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
